// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction / data) arbiter in front of one shared
// memory request port. One transaction is in flight at a time. The request is
// registered onto mem_* and held there until mem_resp completes it.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration on
// contention. Without it, the data side has fixed priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_rmask,
    input  logic [3:0]  i_wmask,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_rmask,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  rmask_q, rmask_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        i_pend, d_pend;
    logic        grant_to_d;
`ifdef MEM_ARB_RR_EN
    logic        last_was_d_q, last_was_d_d;
`endif

    // Pick the winner among pending requesters (only used in IDLE).
    always_comb begin
        i_pend = |(i_rmask | i_wmask);
        d_pend = |(d_rmask | d_wmask);
`ifdef MEM_ARB_RR_EN
        // On contention, the side that was not granted last wins.
        if (i_pend && d_pend) begin
            grant_to_d = ~last_was_d_q;
        end else begin
            grant_to_d = d_pend;
        end
`else
        grant_to_d = d_pend;
`endif
    end

    // Next state and the registered downstream request.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rmask_d = rmask_q;
        wmask_d = wmask_q;
`ifdef MEM_ARB_RR_EN
        last_was_d_d = last_was_d_q;
`endif
        case (state_q)
            IDLE: begin
                // mem_resp is ignored here; only a new request moves us on.
                if (i_pend || d_pend) begin
`ifdef MEM_ARB_RR_EN
                    last_was_d_d = grant_to_d;
`endif
                    if (grant_to_d) begin
                        state_d = SERVE_D;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        rmask_d = d_rmask;
                        wmask_d = d_wmask;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = i_addr;
                        wdata_d = i_wdata;
                        rmask_d = i_rmask;
                        wmask_d = i_wmask;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                // Requester inputs are not looked at; the request stays frozen.
                // Address and write data are kept, only the masks drop.
                if (mem_resp) begin
                    state_d = IDLE;
                    rmask_d = 4'h0;
                    wmask_d = 4'h0;
                end
            end
            default: begin
                state_d = IDLE;
                rmask_d = 4'h0;
                wmask_d = 4'h0;
            end
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rmask_q <= 4'h0;
            wmask_q <= 4'h0;
`ifdef MEM_ARB_RR_EN
            last_was_d_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rmask_q <= rmask_d;
            wmask_q <= wmask_d;
`ifdef MEM_ARB_RR_EN
            last_was_d_q <= last_was_d_d;
`endif
        end
    end

    // Completion steering: only the granted side sees resp and read data.
    // Gated by rst so an abandoned transaction never completes.
    always_comb begin
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        i_rdata = 32'h0;
        d_rdata = 32'h0;
        if (!rst && mem_resp) begin
            if (state_q == SERVE_I) begin
                i_resp  = 1'b1;
                i_rdata = mem_rdata;
            end
            if (state_q == SERVE_D) begin
                d_resp  = 1'b1;
                d_rdata = mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rmask = rmask_q;
    assign mem_wmask = wmask_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 No parameters; all address and data widths SHALL be fixed at 32 bits and all masks at 4 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_addr  input  32  instruction-side request address.
REQ-005 i_rmask / i_wmask  input  4 each  instruction-side byte read and write enables; a nonzero value is a request.
REQ-006 i_wdata  input  32  instruction-side write data.
REQ-007 i_rdata  output  32  instruction-side read data, valid while i_resp=1.
REQ-008 i_resp  output  1  instruction-side one-cycle completion pulse.
REQ-009 d_addr, d_rmask, d_wmask, d_wdata, d_rdata, d_resp: the data-side equivalents of REQ-004..008, with identical widths and directions.
REQ-010 mem_addr  output  32; mem_rmask / mem_wmask  output  4 each; mem_wdata  output  32: shared downstream request.
REQ-011 mem_rdata  input  32; mem_resp  input  1: downstream completion.

Function
REQ-012 FSM states SHALL be IDLE, SERVE_I and SERVE_D.
REQ-013 In IDLE, a requester is pending when (rmask | wmask) != 0.
REQ-014 In IDLE with at least one pending requester, the arbiter SHALL select one requester and register its addr, rmask, wmask and wdata into the mem_* outputs at the clock edge, then enter SERVE_I or SERVE_D.
REQ-015 Request-to-mem latency SHALL be exactly 1 cycle: a request sampled in cycle N appears on mem_* in cycle N+1.
REQ-016 mem_* outputs SHALL hold stable for the whole SERVE state, independent of any requester input changes.
REQ-017 In SERVE_x with mem_resp=1, the arbiter SHALL:
- drive x_resp=1 and x_rdata=mem_rdata combinationally in that same cycle;
- clear mem_rmask and mem_wmask to 0 at the next edge;
- return to IDLE.
REQ-018 The non-granted requester SHALL see resp=0 and rdata=0 at all times.
REQ-019 mem_resp arriving while in IDLE SHALL be ignored.
REQ-020 The minimum turnaround is 2 cycles: IDLE SHALL last at least one cycle between transactions.
REQ-021 A requester that drops its request mid-SERVE SHALL NOT abort the transaction, and its resp pulse SHALL still be issued.
REQ-022 rmask and wmask both nonzero SHALL be forwarded unchanged; legality is the requester's responsibility.
REQ-023 mem_addr and mem_wdata SHALL retain their last value in IDLE; only the masks are cleared.

Reset
REQ-024 On rst=1 at a clock edge, the state SHALL become IDLE and mem_rmask, mem_wmask, mem_addr and mem_wdata SHALL become 0.
REQ-025 While in reset, i_resp and d_resp SHALL be 0 and i_rdata and d_rdata SHALL be 0.
REQ-026 Reset mid-SERVE SHALL abandon the transaction without issuing a resp; a mem_resp arriving afterwards SHALL be ignored per REQ-019.
REQ-027 The round-robin pointer (REQ-029) SHALL reset to "last granted = I", so the first contended grant goes to D.

Configuration
REQ-028 Without MEM_ARB_RR_EN: fixed priority, with D winning whenever both sides are pending in IDLE.
REQ-029 With MEM_ARB_RR_EN defined: a 1-bit last-grant register SHALL be kept.
- On contention, the side not granted last SHALL win.
- Uncontended requests SHALL be granted immediately and SHALL update the register.

Verification
REQ-030 Single read: i_rmask=F, i_addr=0x60 in cycle 0; memory responds with 0x00000013 in cycle 3.
- Expect mem_rmask=F and mem_addr=0x60 in cycles 1-3.
- Expect i_resp=1 and i_rdata=0x13 in cycle 3.
- Expect mem_rmask=0 in cycle 4.
REQ-031 Contention, default build: i and d both request in cycle 0, each memory response takes 1 cycle.
- Expect d served first, with d_resp in cycle 1.
- Expect i served next: request on mem in cycle 3, i_resp in cycle 3.
REQ-032 Contention with MEM_ARB_RR_EN over 4 back-to-back contended rounds: expect grant order D, I, D, I.
REQ-033 Write: d_wmask=3, d_wdata=0xDEADBEEF, d_addr=0x104.
- Expect mem_wmask=3 and mem_wdata=0xDEADBEEF for the full SERVE_D.
- Expect i_resp to stay 0 throughout.
REQ-034 Reset mid-SERVE_I, with mem_resp arriving one cycle after reset is released.
- Expect no i_resp.
- Expect the state to be IDLE and all mem masks 0.
REQ-035 Randomised stress: 60000 cycles of random i/d requests with random memory latency of 0-5 cycles.
- Expect exactly one resp per granted request.
- Expect mem_* never to change during SERVE.
- Expect no cycle in which i_resp and d_resp are both 1.
